mem_port_arbiter: RTL and testbench

// Shares one external req/gnt/rvalid memory port between the core's instruction-fetch

---
 rtl/mem_port_arbiter.sv | 93 +++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/gnt/rvalid memory port between fetch (owner 0) and data (owner 1)
//   clk_i, rst_i (async, active-high)
//   instr_*   : fetch requester (req/addr in, gnt/rvalid/rdata out)
//   data_*    : data requester (req/we/be/addr/wdata in, gnt/rvalid/rdata out)
//   mem_*     : shared memory port (req/we/be/addr/wdata out, gnt/rvalid/rdata in)
//   err_o     : sticky, set by an rvalid arriving with nothing outstanding
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit ARB_MODE = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);
  localparam int AW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t r_state, w_state_nxt;
  logic r_locked_sel, r_rr_last, r_err;
  logic [MAX_OUTSTANDING-1:0] r_own;
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic w_sel, w_req, w_gnt, w_pop, w_head;
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction
  // an ungranted request freezes the selection so the memory sees a stable request
  assign w_sel = (r_state == LOCKED) ? r_locked_sel :
                 (instr_req_i & data_req_i) ? (ARB_MODE ? 1'b1 : ~r_rr_last) : data_req_i;
  assign w_req = ~rst_i & (instr_req_i | data_req_i) & (r_cnt < CW'(MAX_OUTSTANDING));
  assign w_gnt = w_req & mem_gnt_i;
  assign w_pop = mem_rvalid_i & (r_cnt != '0);
  assign w_head = r_own[r_rd];
  assign mem_req_o = w_req;
  assign mem_we_o = w_sel & data_we_i;
  assign mem_be_o = w_sel ? data_be_i : 4'hF;
  assign mem_addr_o = w_sel ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = w_sel ? data_wdata_i : 32'h0;
  assign instr_gnt_o = w_gnt & ~w_sel;
  assign data_gnt_o = w_gnt & w_sel;
  assign instr_rvalid_o = w_pop & ~w_head;
  assign data_rvalid_o = w_pop & w_head;
  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o = mem_rdata_i;
  assign err_o = r_err;
  always_comb begin
    w_state_nxt = (r_state == IDLE) ? ((w_req & ~mem_gnt_i) ? LOCKED : IDLE) : (mem_gnt_i ? IDLE : LOCKED);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_locked_sel <= 1'b0;
      r_rr_last <= 1'b1;
      r_err <= 1'b0;
      r_own <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) r_locked_sel <= w_sel;
      if (w_gnt) begin
        r_own[r_wr] <= w_sel;
        r_wr <= ptr_inc(r_wr);
        r_rr_last <= w_sel;
      end
      if (w_pop) r_rd <= ptr_inc(r_rd);
      r_cnt <= r_cnt + CW'(w_gnt) - CW'(w_pop);
      if (mem_rvalid_i && r_cnt == '0) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of two arbiter configurations against a queue-based model
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic ir[2], dr[2], dwe[2], mg[2], mrv[2];
  logic [31:0] ia[2], da[2], dwd[2], mrd[2];
  logic [3:0] dbe[2];
  logic ig[2], irv[2], dg[2], drv[2], mreq[2], mwe[2], err[2];
  logic [31:0] ird[2], drd[2], maddr[2], mwd[2];
  logic [3:0] mbe[2];
  int checks = 0, errors = 0;
  bit rr[2], lk[2], ls[2], er[2], pi[2], pd[2];
  int oq[2][$];
  mem_port_arbiter #(.MAX_OUTSTANDING(2), .ARB_MODE(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(ir[0]), .instr_addr_i(ia[0]), .instr_gnt_o(ig[0]), .instr_rvalid_o(irv[0]), .instr_rdata_o(ird[0]),
    .data_req_i(dr[0]), .data_we_i(dwe[0]), .data_be_i(dbe[0]), .data_addr_i(da[0]), .data_wdata_i(dwd[0]),
    .data_gnt_o(dg[0]), .data_rvalid_o(drv[0]), .data_rdata_o(drd[0]),
    .mem_req_o(mreq[0]), .mem_we_o(mwe[0]), .mem_be_o(mbe[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwd[0]),
    .mem_gnt_i(mg[0]), .mem_rvalid_i(mrv[0]), .mem_rdata_i(mrd[0]), .err_o(err[0]));
  mem_port_arbiter #(.MAX_OUTSTANDING(4), .ARB_MODE(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(ir[1]), .instr_addr_i(ia[1]), .instr_gnt_o(ig[1]), .instr_rvalid_o(irv[1]), .instr_rdata_o(ird[1]),
    .data_req_i(dr[1]), .data_we_i(dwe[1]), .data_be_i(dbe[1]), .data_addr_i(da[1]), .data_wdata_i(dwd[1]),
    .data_gnt_o(dg[1]), .data_rvalid_o(drv[1]), .data_rdata_o(drd[1]),
    .mem_req_o(mreq[1]), .mem_we_o(mwe[1]), .mem_be_o(mbe[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwd[1]),
    .mem_gnt_i(mg[1]), .mem_rvalid_i(mrv[1]), .mem_rdata_i(mrd[1]), .err_o(err[1]));
  task automatic chk(input string n, input int k, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h at %0t", n, k, a, e, $time);
    end
  endtask
  task automatic model(input int k);
    bit sel, req, gi, gd, pop, hd;
    int cap;
    if (rst) begin
      oq[k].delete();
      rr[k] = 1'b1;
      lk[k] = 1'b0;
      ls[k] = 1'b0;
      er[k] = 1'b0;
    end
    cap = k ? 4 : 2;
    sel = lk[k] ? ls[k] : (ir[k] && dr[k]) ? (k == 1 ? 1'b1 : !rr[k]) : dr[k];
    req = !rst && (ir[k] || dr[k]) && oq[k].size() < cap;
    gi = req && mg[k] && !sel;
    gd = req && mg[k] && sel;
    pop = !rst && mrv[k] && oq[k].size() > 0;
    hd = 1'b0;
    if (pop) hd = (oq[k][0] == 1);
    chk("mem_req", k, 32'(mreq[k]), 32'(req));
    chk("instr_gnt", k, 32'(ig[k]), 32'(gi));
    chk("data_gnt", k, 32'(dg[k]), 32'(gd));
    chk("instr_rvalid", k, 32'(irv[k]), 32'(pop && !hd));
    chk("data_rvalid", k, 32'(drv[k]), 32'(pop && hd));
    chk("instr_rdata", k, ird[k], mrd[k]);
    chk("data_rdata", k, drd[k], mrd[k]);
    chk("err", k, 32'(err[k]), 32'(er[k]));
    if (req) begin
      chk("mem_addr", k, maddr[k], sel ? da[k] : ia[k]);
      chk("mem_we", k, 32'(mwe[k]), sel ? 32'(dwe[k]) : 32'd0);
      chk("mem_be", k, 32'(mbe[k]), sel ? 32'(dbe[k]) : 32'hF);
      chk("mem_wdata", k, mwd[k], sel ? dwd[k] : 32'd0);
    end
    if (!rst) begin
      if (mrv[k] && oq[k].size() == 0) er[k] = 1'b1;
      if (pop) void'(oq[k].pop_front());
      if (gi || gd) begin
        oq[k].push_back(int'(sel));
        rr[k] = sel;
      end
      if (!lk[k] && req && !mg[k]) begin
        lk[k] = 1'b1;
        ls[k] = sel;
      end else if (lk[k] && mg[k]) lk[k] = 1'b0;
    end
    pi[k] = !rst && ir[k] && !gi;
    pd[k] = !rst && dr[k] && !gd;
  endtask
  task automatic eval();
    @(negedge clk);
    model(0);
    model(1);
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      ir[k] = 0; dr[k] = 0; dwe[k] = 0; mg[k] = 0; mrv[k] = 0;
      ia[k] = 0; da[k] = 0; dwd[k] = 0; mrd[k] = 0; dbe[k] = 0;
    end
  endtask
  task automatic rst_pulse();
    rst = 1;
    eval();
    nxt();
    rst = 0;
  endtask
  initial begin
    clr();
    rst = 1;
    eval();
    chk("rst_mem_req", 0, 32'(mreq[0]), 0);
    chk("rst_err", 0, 32'(err[0]), 0);
    nxt();
    rst = 0;
    ir[0] = 1; ia[0] = 32'h100; mg[0] = 1;
    eval();
    chk("t1_gnt", 0, 32'(ig[0]), 1);
    chk("t1_addr", 0, maddr[0], 32'h100);
    nxt();
    clr();
    mrv[0] = 1; mrd[0] = 32'hDEADBEEF;
    eval();
    chk("t1_rvalid", 0, 32'(irv[0]), 1);
    chk("t1_rdata", 0, ird[0], 32'hDEADBEEF);
    chk("t1_drvalid", 0, 32'(drv[0]), 0);
    nxt();
    clr();
    rst_pulse();
    for (int c = 0; c < 6; c++) begin
      ir[0] = 1; dr[0] = 1; mg[0] = 1; mrv[0] = (c > 0);
      eval();
      chk("t2_ignt", 0, 32'(ig[0]), 32'(c % 2 == 0));
      chk("t2_dgnt", 0, 32'(dg[0]), 32'(c % 2 == 1));
      nxt();
    end
    clr();
    mrv[0] = 1;
    eval();
    nxt();
    clr();
    for (int c = 0; c < 4; c++) begin
      ir[1] = 1; dr[1] = 1; mg[1] = 1; mrv[1] = (c > 0);
      eval();
      chk("t3_dgnt", 1, 32'(dg[1]), 1);
      chk("t3_ignt", 1, 32'(ig[1]), 0);
      nxt();
    end
    clr();
    mrv[1] = 1;
    eval();
    nxt();
    clr();
    ir[0] = 1; ia[0] = 32'h200;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        dr[0] = 1; da[0] = 32'h300; dwe[0] = 1; dbe[0] = 4'h3; dwd[0] = 32'h55;
      end
      eval();
      chk("t4_hold_addr", 0, maddr[0], 32'h200);
      chk("t4_no_dgnt", 0, 32'(dg[0]), 0);
      nxt();
    end
    mg[0] = 1;
    eval();
    chk("t4_ignt", 0, 32'(ig[0]), 1);
    chk("t4_addr", 0, maddr[0], 32'h200);
    nxt();
    ir[0] = 0;
    eval();
    chk("t4_dgnt", 0, 32'(dg[0]), 1);
    chk("t4_daddr", 0, maddr[0], 32'h300);
    chk("t4_we", 0, 32'(mwe[0]), 1);
    nxt();
    clr();
    mrv[0] = 1; mrd[0] = 32'h11;
    eval();
    chk("t4_resp_i", 0, 32'(irv[0]), 1);
    nxt();
    mrd[0] = 32'h22;
    eval();
    chk("t4_resp_d", 0, 32'(drv[0]), 1);
    nxt();
    clr();
    ir[0] = 1; dr[0] = 1; mg[0] = 1;
    eval();
    chk("t5_g0", 0, 32'(ig[0]), 1);
    nxt();
    eval();
    chk("t5_g1", 0, 32'(dg[0]), 1);
    nxt();
    eval();
    chk("t5_full", 0, 32'(mreq[0]), 0);
    nxt();
    mrv[0] = 1;
    eval();
    chk("t5_nobypass", 0, 32'(mreq[0]), 0);
    chk("t5_irv", 0, 32'(irv[0]), 1);
    nxt();
    mrv[0] = 0;
    eval();
    chk("t5_resume", 0, 32'(mreq[0]), 1);
    chk("t5_igrant", 0, 32'(ig[0]), 1);
    nxt();
    clr();
    mrv[0] = 1;
    eval();
    chk("t5_drv", 0, 32'(drv[0]), 1);
    nxt();
    eval();
    chk("t5_irv2", 0, 32'(irv[0]), 1);
    nxt();
    clr();
    mrv[0] = 1;
    eval();
    chk("t6_no_irv", 0, 32'(irv[0]), 0);
    chk("t6_no_drv", 0, 32'(drv[0]), 0);
    nxt();
    mrv[0] = 0;
    eval();
    chk("t6_err", 0, 32'(err[0]), 1);
    nxt();
    eval();
    chk("t6_sticky", 0, 32'(err[0]), 1);
    nxt();
    ir[0] = 1; mg[0] = 1;
    eval();
    nxt();
    rst = 1;
    eval();
    chk("t6_rst_req", 0, 32'(mreq[0]), 0);
    chk("t6_rst_gnt", 0, 32'(ig[0]), 0);
    chk("t6_rst_err", 0, 32'(err[0]), 0);
    nxt();
    rst = 0;
    clr();
    mrv[0] = 1;
    eval();
    chk("t6_late_irv", 0, 32'(irv[0]), 0);
    nxt();
    clr();
    eval();
    chk("t6_late_err", 0, 32'(err[0]), 1);
    nxt();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom % 300 == 0);
      for (int k = 0; k < 2; k++) begin
        if (!pi[k]) begin
          ir[k] = 1'($urandom % 2);
          ia[k] = $urandom;
        end
        if (!pd[k]) begin
          dr[k] = 1'($urandom % 2);
          dwe[k] = 1'($urandom % 2);
          dbe[k] = 4'($urandom);
          da[k] = $urandom;
          dwd[k] = $urandom;
        end
        mg[k] = ($urandom % 3 != 0);
        mrv[k] = oq[k].size() > 0 ? 1'($urandom % 2) : ($urandom % 40 == 0);
        mrd[k] = $urandom;
      end
      eval();
      nxt();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
